ysyx_24100006_wbu: RTL and testbench

YSYX_24100006_WBU -- requirements
Module: ysyx_24100006_wbu

---
 rtl/ysyx_24100006_wbu.sv | 162 ++++++++++++++++
 tb/tb_ysyx_24100006_wbu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_wbu.sv
// ============================================================================
//  Module      : ysyx_24100006_wbu
//  Description : Write-back stage that merges EXU and LSU results into the
//                GPR write port, with a one-entry EXU skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_24100006_wbu #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic                  exu_wen,
    input  logic [DATA_WIDTH-1:0] exu_data,

    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [2:0]            lsu_funct3,
    input  logic [1:0]            lsu_addr_lo,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  gpr_wen,
    output logic [ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,

    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data,

    output logic [31:0]           commit_cnt
);

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    logic                  wb_valid;
    logic                  wb_wen;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    logic                  sk_valid;
    logic                  sk_wen;
    logic [ADDR_WIDTH-1:0] sk_rd;
    logic [DATA_WIDTH-1:0] sk_data;

    logic                  wb_valid_nxt;
    logic                  wb_wen_nxt;
    logic [ADDR_WIDTH-1:0] wb_rd_nxt;
    logic [DATA_WIDTH-1:0] wb_data_nxt;

    logic                  exu_hs;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign lsu_ready = 1'b1;
    assign exu_ready = !sk_valid;
    assign exu_hs    = exu_valid && exu_ready;

    // Load alignment: byte picked by addr_lo, halfword by addr_lo[1] only
    always_comb begin
        ld_byte = lsu_rdata[7:0];
        case (lsu_addr_lo)
            2'd0:    ld_byte = lsu_rdata[7:0];
            2'd1:    ld_byte = lsu_rdata[15:8];
            2'd2:    ld_byte = lsu_rdata[23:16];
            default: ld_byte = lsu_rdata[31:24];
        endcase
        ld_half = lsu_addr_lo[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];

        case (lsu_funct3)
            F3_LB:   load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            F3_LH:   load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: load_data = lsu_rdata;
        endcase
    end

    // WB input priority: LSU, then skid, then live EXU handshake
    always_comb begin
        wb_valid_nxt = 1'b0;
        wb_wen_nxt   = 1'b0;
        wb_rd_nxt    = wb_rd;
        wb_data_nxt  = wb_data;
        if (lsu_valid) begin
            wb_valid_nxt = 1'b1;
            wb_wen_nxt   = 1'b1;
            wb_rd_nxt    = lsu_rd;
            wb_data_nxt  = load_data;
        end else if (sk_valid) begin
            wb_valid_nxt = 1'b1;
            wb_wen_nxt   = sk_wen;
            wb_rd_nxt    = sk_rd;
            wb_data_nxt  = sk_data;
        end else if (exu_hs) begin
            wb_valid_nxt = 1'b1;
            wb_wen_nxt   = exu_wen;
            wb_rd_nxt    = exu_rd;
            wb_data_nxt  = exu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= wb_valid_nxt;
            wb_wen   <= wb_wen_nxt;
            wb_rd    <= wb_rd_nxt;
            wb_data  <= wb_data_nxt;
        end
    end

    // A handshake implies an empty skid, so EXU only parks here behind a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_valid <= 1'b0;
            sk_wen   <= 1'b0;
            sk_rd    <= '0;
            sk_data  <= '0;
        end else if (exu_hs && lsu_valid) begin
            sk_valid <= 1'b1;
            sk_wen   <= exu_wen;
            sk_rd    <= exu_rd;
            sk_data  <= exu_data;
        end else if (sk_valid && !lsu_valid) begin
            sk_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt <= 32'd0;
        end else if (wb_valid) begin
            commit_cnt <= commit_cnt + 32'd1;
        end
    end

    assign gpr_wen   = wb_valid && wb_wen && (wb_rd != '0);
    assign gpr_waddr = wb_rd;
    assign gpr_wdata = wb_data;

    assign fwd_valid = gpr_wen;
    assign fwd_rd    = gpr_waddr;
    assign fwd_data  = gpr_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100006_wbu.sv
// ============================================================================
//  Module      : tb_ysyx_24100006_wbu
//  Description : Directed-vector bench for the write-back stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_24100006_wbu;

    logic        clk;
    logic        rst_n;
    logic        exu_valid;
    logic        exu_ready;
    logic [3:0]  exu_rd;
    logic        exu_wen;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [3:0]  lsu_rd;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_addr_lo;
    logic [31:0] lsu_rdata;
    logic        gpr_wen;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] commit_cnt;

    int n_vec;
    int n_err;
    int retired;

    ysyx_24100006_wbu #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_rd      (exu_rd),
        .exu_wen     (exu_wen),
        .exu_data    (exu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_funct3  (lsu_funct3),
        .lsu_addr_lo (lsu_addr_lo),
        .lsu_rdata   (lsu_rdata),
        .gpr_wen     (gpr_wen),
        .gpr_waddr   (gpr_waddr),
        .gpr_wdata   (gpr_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .commit_cnt  (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exu_valid   = 1'b0;
        exu_rd      = 4'd0;
        exu_wen     = 1'b0;
        exu_data    = 32'd0;
        lsu_valid   = 1'b0;
        lsu_rd      = 4'd0;
        lsu_funct3  = 3'd0;
        lsu_addr_lo = 2'd0;
        lsu_rdata   = 32'd0;
    endtask

    task automatic drive_exu(input logic [3:0] rd, input logic wen, input logic [31:0] data);
        exu_valid = 1'b1;
        exu_rd    = rd;
        exu_wen   = wen;
        exu_data  = data;
    endtask

    task automatic drive_lsu(input logic [3:0] rd, input logic [2:0] f3,
                             input logic [1:0] lo, input logic [31:0] rdata);
        lsu_valid   = 1'b1;
        lsu_rd      = rd;
        lsu_funct3  = f3;
        lsu_addr_lo = lo;
        lsu_rdata   = rdata;
    endtask

    task automatic check_write(input string tag, input logic [3:0] rd, input logic [31:0] data);
        check({tag, " wen"},   {31'd0, gpr_wen},   32'd1);
        check({tag, " waddr"}, {28'd0, gpr_waddr}, {28'd0, rd});
        check({tag, " wdata"}, gpr_wdata,          data);
    endtask

    // Load formatting vectors: funct3, addr_lo, raw word, expected result
    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] rdata;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t lv [7];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        retired = 0;
        idle();
        rst_n = 1'b0;

        lv[0] = '{3'd5, 2'd2, 32'h8001_0000, 32'h0000_8001};
        lv[1] = '{3'd1, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
        lv[2] = '{3'd4, 2'd3, 32'hAB00_0000, 32'h0000_00AB};
        lv[3] = '{3'd1, 2'd3, 32'h8001_0000, 32'hFFFF_8001};
        lv[4] = '{3'd0, 2'd1, 32'h0000_7F00, 32'h0000_007F};
        lv[5] = '{3'd2, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        lv[6] = '{3'd3, 2'd0, 32'h1234_5678, 32'h1234_5678};

        #12;
        check("rst gpr_wen",    {31'd0, gpr_wen},   32'd0);
        check("rst fwd_valid",  {31'd0, fwd_valid}, 32'd0);
        check("rst exu_ready",  {31'd0, exu_ready}, 32'd1);
        check("rst lsu_ready",  {31'd0, lsu_ready}, 32'd1);
        check("rst commit_cnt", commit_cnt,         32'd0);
        #6 rst_n = 1'b1;
        step();

        // EXU only
        drive_exu(4'd5, 1'b1, 32'h1234);
        step();
        idle();
        retired++;
        check_write("exu", 4'd5, 32'h1234);
        check("exu fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check("exu fwd_rd",    {28'd0, fwd_rd},    32'd5);
        check("exu fwd_data",  fwd_data,           32'h1234);
        step();
        check("exu commit_cnt", commit_cnt, retired);
        check("exu idle wen", {31'd0, gpr_wen}, 32'd0);

        // LSU/EXU collision: load first, EXU parks in skid
        drive_lsu(4'd3, 3'd0, 2'd2, 32'h0080_FF00);
        drive_exu(4'd4, 1'b1, 32'd7);
        step();
        idle();
        retired += 2;
        check_write("coll ld", 4'd3, 32'hFFFF_FF80);
        check("coll ready0", {31'd0, exu_ready}, 32'd0);
        step();
        check_write("coll exu", 4'd4, 32'd7);
        check("coll ready1", {31'd0, exu_ready}, 32'd1);
        step();
        check("coll commit_cnt", commit_cnt, retired);

        // Load formatting, back-to-back loads
        foreach (lv[i]) begin
            drive_lsu(4'(i + 1), lv[i].f3, lv[i].lo, lv[i].rdata);
            step();
            retired++;
            check_write($sformatf("load%0d", i), 4'(i + 1), lv[i].exp);
        end
        idle();
        step();
        check("load commit_cnt", commit_cnt, retired);

        // x0 write and wen=0 still retire
        drive_exu(4'd0, 1'b1, 32'hFFFF_FFFF);
        step();
        drive_exu(4'd6, 1'b0, 32'h6666);
        check("x0 gpr_wen", {31'd0, gpr_wen}, 32'd0);
        check("x0 fwd_valid", {31'd0, fwd_valid}, 32'd0);
        step();
        idle();
        check("nowen gpr_wen", {31'd0, gpr_wen}, 32'd0);
        retired += 2;
        step();
        check("nowrite commit_cnt", commit_cnt, retired);

        // Four back-to-back loads with EXU held valid
        drive_exu(4'd12, 1'b1, 32'hCAFE);
        for (int i = 0; i < 4; i++) begin
            drive_lsu(4'(8 + i), 3'd2, 2'd0, 32'(100 + i));
            step();
            check_write($sformatf("b2b ld%0d", i), 4'(8 + i), 32'(100 + i));
            check($sformatf("b2b ready%0d", i), {31'd0, exu_ready}, 32'd0);
        end
        lsu_valid = 1'b0;
        step();
        exu_valid = 1'b0;
        check_write("b2b exu", 4'd12, 32'hCAFE);
        check("b2b ready", {31'd0, exu_ready}, 32'd1);
        retired += 5;
        step();
        idle();
        check("b2b once", {31'd0, gpr_wen}, 32'd0);
        step();
        check("b2b commit_cnt", commit_cnt, retired);

        // Asynchronous reset with WB and skid both occupied
        drive_lsu(4'd9, 3'd2, 2'd0, 32'h55);
        drive_exu(4'd10, 1'b1, 32'h66);
        step();
        idle();
        check("pre-rst ready", {31'd0, exu_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("arst gpr_wen",    {31'd0, gpr_wen},   32'd0);
        check("arst fwd_valid",  {31'd0, fwd_valid}, 32'd0);
        check("arst commit_cnt", commit_cnt,         32'd0);
        check("arst exu_ready",  {31'd0, exu_ready}, 32'd1);
        step();
        #2 rst_n = 1'b1;
        retired = 0;
        step();
        check("post-rst wen0", {31'd0, gpr_wen}, 32'd0);
        step();
        check("post-rst wen1", {31'd0, gpr_wen}, 32'd0);
        check("post-rst commit_cnt", commit_cnt, retired);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
